// File: rtl/mc_main_controller.sv
`default_nettype none
// ============================================================================
// Module  : mc_main_controller
// Brief   : Multicycle RV32 main control FSM (fetch/decode/execute sequencing).
// Revision: 1.0 - initial release
// ============================================================================
module mc_main_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALR2    = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          C_OP_LOAD, C_OP_STORE: w_next = S_MEMADR;
          C_OP_RTYPE:            w_next = S_EXECR;
          C_OP_ITYPE:            w_next = S_EXECI;
          C_OP_BRANCH:           w_next = S_BRANCH;
          C_OP_JAL:              w_next = S_JAL;
          C_OP_JALR:             w_next = S_JALR;
          C_OP_LUI:              w_next = S_LUI;
          default:               w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (op == C_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL, S_JALR2: w_next = S_ALUWB;
      S_JALR:   w_next = S_JALR2;
      default:  w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low, including the decode-dependent ones.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    ALUOp     = 2'b00;
    illegal   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == C_OP_JAL) ? 3'b011 : 3'b010;
          case (op)
            C_OP_LOAD, C_OP_STORE, C_OP_RTYPE, C_OP_ITYPE,
            C_OP_BRANCH, C_OP_JAL, C_OP_JALR, C_OP_LUI: illegal = 1'b0;
            default:                                    illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == C_OP_STORE) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b11;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          // Signed/unsigned less-than branches test the SLT result, not equality.
          case (funct3)
            3'b000, 3'b101, 3'b111: PCWrite = Zero;
            3'b001, 3'b100, 3'b110: PCWrite = ~Zero;
            default:                illegal = 1'b1;
          endcase
        end
        S_JAL, S_JALR2: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_JALR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_LUI: begin
          ImmSrc    = 3'b100;
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mc_main_controller.md
MC_MAIN_CONTROLLER -- requirements
Module: mc_main_controller

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is synchronous and active-high.
REQ-002 The ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- op  in  7  instruction opcode from the instruction register.
- funct3  in  3  instruction funct3.
- Zero  in  1  ALU zero flag for the current cycle.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=Result.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  load enable for the instruction register and OldPC.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ImmExt, 10=constant 4.
- ImmSrc  out  3  immediate type: 000=I, 001=S, 010=B, 011=J, 100=U.
- ALUOp  out  2  to the ALU decoder: 00=add, 01=branch compare, 10=R-type, 11=I-type ALU.
- illegal  out  1  one-cycle pulse on an unsupported opcode or branch funct3.

Function
REQ-003 The block SHALL be a 4-bit registered-state FSM with 14 states.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR2, LUI.
REQ-004 Unless a state lists a value, every output SHALL be 0.
REQ-005 Outputs SHALL be combinational from the state, except for three signals: ImmSrc in DECODE and MEMADR depends on op, PCWrite in BRANCH depends on funct3 and Zero, and illegal depends on op or funct3.
REQ-006 FETCH SHALL drive IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10 and ALUOp=00, then go to DECODE.
REQ-007 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01 and ALUOp=00, with ImmSrc=011 if op=1101111 and ImmSrc=010 otherwise.
REQ-008 DECODE SHALL go to the next state selected by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- 1100111 -> JALR.
- 0110111 -> LUI.
- any other op -> FETCH, with illegal=1 for that cycle.
REQ-009 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01 and ALUOp=00, with ImmSrc=001 if op=0100011 and 000 otherwise; it SHALL go to MEMWRITE for op=0100011 and to MEMREAD otherwise.
REQ-010 MEMREAD SHALL drive AdrSrc=1 and ResultSrc=00, then go to MEMWB.
REQ-011 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-012 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00 and MemWrite=1, then go to FETCH.
REQ-013 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00 and ALUOp=10, then go to ALUWB.
REQ-014 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=000 and ALUOp=11, then go to ALUWB.
REQ-015 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-016 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01 and ResultSrc=00, then go to FETCH.
REQ-017 In BRANCH, PCWrite SHALL follow funct3:
- 000 -> PCWrite=Zero.
- 001 -> PCWrite=~Zero.
- 100 or 110 -> PCWrite=~Zero (ALU SLT result nonzero).
- 101 or 111 -> PCWrite=Zero.
- 010 or 011 -> PCWrite=0 and illegal=1.
REQ-018 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-019 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=000 and ALUOp=00, then go to JALR2.
REQ-020 JALR2 SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-021 LUI SHALL drive ImmSrc=100, ResultSrc=11 and RegWrite=1, then go to FETCH.
REQ-022 Instruction latency in cycles, counted from FETCH through the last state before FETCH, SHALL be:
- lui 3, branch 3.
- R-type 4, I-type ALU 4, sw 4, jal 4.
- lw 5, jalr 5.
REQ-023 At most one of MemWrite and RegWrite SHALL be 1 in any cycle.
REQ-024 IRWrite SHALL be 1 only in FETCH.
REQ-025 The block SHALL have no wait states: every state transition happens unconditionally on the next clock edge.

Reset
REQ-026 While rst=1 at a rising edge, the next state SHALL be FETCH.
REQ-027 During any cycle with rst=1, all outputs including illegal SHALL be 0.
REQ-028 A reset asserted mid-instruction SHALL abandon that instruction with no further write enables, and FETCH SHALL follow the first clock edge after rst falls.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then op=0110011 -> FETCH, DECODE, EXECR (ALUOp=10), ALUWB (RegWrite=1), FETCH; 4 cycles.
- op=0000011 -> MEMADR (ImmSrc=000), MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); op=0100011 -> MEMWRITE with MemWrite=1 for exactly 1 cycle.
- op=1100011 with funct3=000/Zero=1 -> PCWrite=1 in BRANCH; funct3=001/Zero=1 -> PCWrite=0; funct3=100/Zero=0 -> PCWrite=1; funct3=010 -> PCWrite=0 and illegal=1.
- op=1100111 -> JALR, JALR2 (PCWrite=1), ALUWB (RegWrite=1); op=0110111 -> LUI (ResultSrc=11, ImmSrc=100, RegWrite=1), 3 cycles total.
- op=1111111 in DECODE -> illegal=1 for 1 cycle and next state FETCH, with no write enable asserted.
- rst=1 during MEMWRITE -> MemWrite=0 that cycle, FETCH the cycle after rst falls.
